// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad over latch/clk/data and presents registered active-high button levels.
// Ports: clk, rst_n (async active-low); pad_data in (active-low serial); pad_latch, pad_clk out;
//   A, B, select, start, up, down, left, right out (1 = pressed); buttons_valid out (1-cycle commit pulse).
// Define PAD_SOCD_EN to cancel opposing directions (up+down, left+right) at commit.
module nes_pad_reader #(
  parameter int CLK_DIV    = 4,
  parameter int POLL_TICKS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic buttons_valid
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(POLL_TICKS + 1);
  typedef enum logic [2:0] {S_WAIT, S_LATCH, S_SHIFT_LO, S_SHIFT_HI, S_COMMIT} state_t;
  state_t        state;
  logic [1:0]    sync;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    bit_idx;
  logic          latch_tick;
  logic [7:0]    shift;
  logic [7:0]    pressed;
  logic [7:0]    btn_next;
  logic          tick;
  logic          pad_s;
  assign pad_s   = sync[1];
  assign tick    = div_cnt == DW'(CLK_DIV - 1);
  assign pressed = ~{pad_s, shift[6:0]};
`ifdef PAD_SOCD_EN
  assign btn_next = pressed & ~{{2{pressed[7] & pressed[6]}}, {2{pressed[5] & pressed[4]}}, 4'b0};
`else
  assign btn_next = pressed;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_WAIT;
      sync          <= 2'b11;
      div_cnt       <= '0;
      poll_cnt      <= '0;
      bit_idx       <= '0;
      latch_tick    <= 1'b0;
      shift         <= '1;
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b0;
      buttons_valid <= 1'b0;
      {right, left, down, up, start, select, B, A} <= '0;
    end else begin
      sync          <= {sync[0], pad_data};
      buttons_valid <= 1'b0;
      // COMMIT adds one cycle; freezing the divider keeps the poll period fixed.
      if (state != S_COMMIT) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      case (state)
        S_WAIT: if (tick) begin
          poll_cnt <= (poll_cnt == PW'(POLL_TICKS - 1)) ? '0 : poll_cnt + 1'b1;
          if (poll_cnt == PW'(POLL_TICKS - 1)) begin
            state     <= S_LATCH;
            pad_latch <= 1'b1;
          end
        end
        S_LATCH: if (tick) begin
          latch_tick <= ~latch_tick;
          if (latch_tick) begin
            state     <= S_SHIFT_LO;
            pad_latch <= 1'b0;
            bit_idx   <= '0;
          end
        end
        S_SHIFT_LO: if (tick) begin
          shift[bit_idx] <= pad_s;
          if (bit_idx == 3'd7) begin
            state         <= S_COMMIT;
            buttons_valid <= 1'b1;
            {right, left, down, up, start, select, B, A} <= btn_next;
          end else begin
            state   <= S_SHIFT_HI;
            pad_clk <= 1'b1;
          end
        end
        S_SHIFT_HI: if (tick) begin
          state   <= S_SHIFT_LO;
          pad_clk <= 1'b0;
          bit_idx <= bit_idx + 1'b1;
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: randomized scoreboard bench with a behavioural pad and button model.
module tb_nes_pad_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pad_data, pad_latch, pad_clk, A, B, select, start, up, down, left, right, buttons_valid;
  logic [7:0] pressed = 8'h00;
  logic [7:0] snap = 8'h00;
  int idx = 8;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  logic [7:0] btns;
  nes_pad_reader #(.CLK_DIV(4), .POLL_TICKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .A(A), .B(B), .select(select), .start(start), .up(up), .down(down), .left(left), .right(right),
    .buttons_valid(buttons_valid)
  );
  always #5 clk = ~clk;
  assign btns = {right, left, down, up, start, select, B, A};
  assign pad_data = (idx < 8) ? ~snap[idx] : 1'b1;
  function automatic logic [7:0] expect_btn(input logic [7:0] p);
    logic [7:0] e = p;
`ifdef PAD_SOCD_EN
    if (p[4] && p[5]) e[5:4] = 2'b00;
    if (p[6] && p[7]) e[7:6] = 2'b00;
`endif
    return e;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
  // Pad: snapshot the pressed set on latch, advance one bit per pad_clk rise.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      snap = pressed;
      idx = 0;
      sb.push_back(expect_btn(pressed));
    end else idx++;
  end
  logic prev_latch = 0, prev_pclk = 0, seen_latch = 0, have_prev = 0, changed = 0;
  int latch_start = 0, pclk_rises = 0, last_valid = 0, valids_seen = 0;
  logic [7:0] last_btn = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_latch = 0; prev_pclk = 0; seen_latch = 0; have_prev = 0; changed = 0;
      pclk_rises = 0; valids_seen = 0; last_btn = 0;
    end else begin
      if (cyc == 32) chk("no_early_valid", valids_seen, 0);
      if (pad_latch && !prev_latch) begin
        if (!seen_latch) chk("first_latch_cycle", cyc, 32);
        seen_latch = 1;
        latch_start = cyc;
        pclk_rises = 0;
      end
      if (!pad_latch && prev_latch) chk("latch_width", cyc - latch_start, 8);
      if (pad_clk && !prev_pclk) pclk_rises++;
      if (buttons_valid) begin
        valids_seen++;
        chk("pad_clk_rises", pclk_rises, 7);
        chk("hold_between_valid", int'(changed), 0);
        if (have_prev) chk("poll_period", cyc - last_valid, 101);
        have_prev = 1;
        last_valid = cyc;
        chk("scoreboard_has_entry", int'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("buttons", int'(btns), int'(sb.pop_front()));
        last_btn = btns;
        changed = 0;
      end else if (btns != last_btn) changed = 1;
      prev_latch = pad_latch;
      prev_pclk = pad_clk;
    end
  end
  task automatic wait_valids(input int n);
    int got = 0;
    for (int c = 0; c < 200 * n && got < n; c++) begin
      @(negedge clk);
      if (buttons_valid) got++;
    end
    chk("valid_timeout", got, n);
  endtask
  task automatic wait_pclk_rises(input int n);
    int got = 0;
    logic p = pad_clk;
    for (int c = 0; c < 300 && got < n; c++) begin
      @(negedge clk);
      if (pad_clk && !p) got++;
      p = pad_clk;
    end
    chk("pclk_timeout", got, n);
  endtask
  initial begin
    #1;
    chk("reset_buttons", int'(btns), 0);
    chk("reset_latch", int'(pad_latch), 0);
    chk("reset_pclk", int'(pad_clk), 0);
    chk("reset_valid", int'(buttons_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valids(1);
    pressed = 8'h81;
    wait_valids(1);
    repeat (10) @(negedge clk);
    pressed = 8'h32;
    wait_valids(1);
    for (int i = 0; i < 8; i++) begin
      pressed = 8'(1 << i);
      wait_valids(1);
    end
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      pressed = 8'($urandom);
      wait_valids(1);
    end
    pressed = 8'hF0;
    wait_valids(1);
    pressed = 8'hFF;
    wait_pclk_rises(4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pclk", int'(pad_clk), 0);
    chk("async_rst_latch", int'(pad_latch), 0);
    chk("async_rst_valid", int'(buttons_valid), 0);
    chk("async_rst_buttons", int'(btns), 0);
    sb.delete();
    pressed = 8'h5A;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valids(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
